// File: rtl/arb_pkg.sv
// Shared types and constants for the round-robin arbiter and its grant decode.
package arb_pkg;
  localparam int NUM_REQ = 8;
  localparam int SEL_W   = $clog2(NUM_REQ);

  typedef enum logic {IDLE, GRANT} arb_state_t;
endpackage

// File: rtl/dmux_8_way.sv
// 1-to-8 demultiplexer: routes `in` to the output bit addressed by `select`.
module dmux_8_way
  import arb_pkg::*;
(
  input  logic             in,
  input  logic [SEL_W-1:0] select,
  output logic [NUM_REQ-1:0] out
);

  // NOTE: every always_comb output is given a default before any conditional
  // assignment so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    out         = '0;
    out[select] = in;
  end

endmodule

// File: rtl/dmux_8_way_arbiter.sv
// Round-robin owner arbiter for a shared 8-way demultiplexed resource, with
// release on done, request drop, or a bounded hold time.
module dmux_8_way_arbiter
  import arb_pkg::*;
#(
  parameter int MAX_HOLD = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_REQ-1:0] req,
  input  logic               done,
  output logic               grant_valid,
  output logic [SEL_W-1:0]   select,
  output logic [NUM_REQ-1:0] grant,
  output logic               timeout
);

  localparam int                CNT_W    = $clog2(MAX_HOLD + 1);
  localparam logic [CNT_W-1:0]  HOLD_MAX = CNT_W'(MAX_HOLD);
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);

  arb_state_t       state, state_d;
  logic [SEL_W-1:0] select_d;
  logic [SEL_W-1:0] last, last_d;
  logic [CNT_W-1:0] hold_cnt, hold_d;
  logic             timeout_d;

  logic             owner_req;
  logic             at_limit;
  logic             release_now;

  // Rotate so that last+1 sits at bit 0, take the lowest set bit, then map
  // the offset back to an absolute requester index.
  function automatic logic [SEL_W-1:0] rr_pick(input logic [NUM_REQ-1:0] r,
                                               input logic [SEL_W-1:0]   lst);
    logic [SEL_W-1:0]   base;
    logic [NUM_REQ-1:0] rot;
    logic [SEL_W-1:0]   off;
    base = lst + SEL_W'(1);
    for (int i = 0; i < NUM_REQ; i++) begin
      rot[i] = r[base + SEL_W'(i)];
    end
    off = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (rot[i]) off = SEL_W'(i);
    end
    return base + off;
  endfunction

  assign owner_req   = req[select];
  assign at_limit    = (hold_cnt == HOLD_MAX);
  assign release_now = done || !owner_req || at_limit;

  always_comb begin
    state_d   = state;
    select_d  = select;
    last_d    = last;
    hold_d    = hold_cnt;
    timeout_d = 1'b0;
    case (state)
      IDLE: begin
        if (|req) begin
          state_d  = GRANT;
          select_d = rr_pick(req, last);
          last_d   = select_d;
          hold_d   = CNT_ONE;
        end
      end
      GRANT: begin
        if (release_now) begin
          state_d   = IDLE;
          // Flag only a forced release: owner still wanted it and never said done.
          timeout_d = !done && owner_req;
        end else begin
          hold_d = hold_cnt + CNT_ONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values and the update order inside the block is irrelevant.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      select   <= '0;
      last     <= SEL_W'(NUM_REQ - 1);
      hold_cnt <= '0;
      timeout  <= 1'b0;
    end else begin
      state    <= state_d;
      select   <= select_d;
      last     <= last_d;
      hold_cnt <= hold_d;
      timeout  <= timeout_d;
    end
  end

  assign grant_valid = (state == GRANT);

  dmux_8_way u_grant_dmux (
    .in     (grant_valid),
    .select (select),
    .out    (grant)
  );

endmodule
